// File: rtl/multi_channel_debouncer.sv
// N-channel debouncer: shared sample prescaler, per-channel 2-flop synchroniser
// and a four-state stability FSM emitting registered level and rise/fall pulses.
module multi_channel_debouncer #(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned TICK_BITS    = 5,
  parameter int unsigned STABLE_TICKS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                changed
);

  localparam int unsigned      CNT_W    = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    WAIT_1 = 2'd1,
    ONE    = 2'd2,
    WAIT_0 = 2'd3
  } state_t;

  logic [TICK_BITS-1:0] r_presc;
  logic                 w_tick;
  logic [CHANNELS-1:0]  r_sync1;
  logic [CHANNELS-1:0]  r_sync2;
  logic [CHANNELS-1:0]  w_rise_nxt;
  logic [CHANNELS-1:0]  w_fall_nxt;
  logic                 r_changed;

  // Free-running sample prescaler shared by all channels
  always_ff @(posedge clk) begin
    if (rst) r_presc <= '0;
    else     r_presc <= r_presc + TICK_BITS'(1);
  end

  assign w_tick = (r_presc == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out;
    logic             r_rise;
    logic             r_fall;
    logic             w_s;
    logic             w_last;

    assign w_s    = r_sync2[g];
    assign w_last = w_tick && (r_cnt == CNT_LAST);

    // A reversal of s inside a WAIT state takes priority over the tick
    assign w_rise_nxt[g] = (r_state == WAIT_1) &&  w_s && w_last;
    assign w_fall_nxt[g] = (r_state == WAIT_0) && !w_s && w_last;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= ZERO;
        r_cnt   <= '0;
        r_out   <= 1'b0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
      end else begin
        r_rise <= w_rise_nxt[g];
        r_fall <= w_fall_nxt[g];
        case (r_state)
          ZERO: begin
            if (w_s) begin
              r_state <= WAIT_1;
              r_cnt   <= '0;
            end
          end
          WAIT_1: begin
            if (!w_s) begin
              r_state <= ZERO;
            end else if (w_tick) begin
              if (r_cnt == CNT_LAST) begin
                r_state <= ONE;
                r_out   <= 1'b1;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
          ONE: begin
            if (!w_s) begin
              r_state <= WAIT_0;
              r_cnt   <= '0;
            end
          end
          WAIT_0: begin
            if (w_s) begin
              r_state <= ONE;
            end else if (w_tick) begin
              if (r_cnt == CNT_LAST) begin
                r_state <= ZERO;
                r_out   <= 1'b0;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
          default: begin
            r_state <= ZERO;
            r_cnt   <= '0;
            r_out   <= 1'b0;
          end
        endcase
      end
    end

    assign out[g]  = r_out;
    assign rise[g] = r_rise;
    assign fall[g] = r_fall;
  end

  always_ff @(posedge clk) begin
    if (rst) r_changed <= 1'b0;
    else     r_changed <= |(w_rise_nxt | w_fall_nxt);
  end

  assign changed = r_changed;

endmodule

// File: tb/tb_multi_channel_debouncer.sv
// Self-checking bench for multi_channel_debouncer: segment table, corner-case
// sequences and a per-cycle comparison against a disagreement-run reference model.
module tb_multi_channel_debouncer;

  localparam int CH     = 4;
  localparam int TBITS  = 5;
  localparam int STABLE = 4;
  localparam int TPER   = 1 << TBITS;
  localparam int LAT_MIN = (STABLE - 1) * TPER + 3;
  localparam int LAT_MAX = STABLE * TPER + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] din = '0;
  logic [CH-1:0] dout;
  logic [CH-1:0] drise;
  logic [CH-1:0] dfall;
  logic          dchg;

  int checks = 0;
  int errors = 0;

  multi_channel_debouncer #(
    .CHANNELS(CH), .TICK_BITS(TBITS), .STABLE_TICKS(STABLE)
  ) dut (
    .clk(clk), .rst(rst), .in(din), .out(dout),
    .rise(drise), .fall(dfall), .changed(dchg)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted once s has disagreed with out for an
  // unbroken run whose later cycles contained STABLE sample ticks.
  logic [CH-1:0] m_s1, m_s2, m_out, m_rise, m_fall;
  logic          m_chg;
  int            m_presc;
  int            run_len [CH];
  int            run_ticks [CH];

  task automatic model_step();
    bit tick;
    if (rst) begin
      m_presc = 0; m_s1 = '0; m_s2 = '0; m_out = '0;
      m_rise = '0; m_fall = '0; m_chg = 1'b0;
      for (int c = 0; c < CH; c++) begin run_len[c] = 0; run_ticks[c] = 0; end
    end else begin
      tick = (m_presc == TPER - 1);
      m_rise = '0; m_fall = '0;
      for (int c = 0; c < CH; c++) begin
        if (m_s2[c] != m_out[c]) begin
          if (run_len[c] > 0 && tick) run_ticks[c]++;
          run_len[c]++;
          if (run_ticks[c] == STABLE) begin
            m_out[c] = m_s2[c];
            if (m_s2[c]) m_rise[c] = 1'b1; else m_fall[c] = 1'b1;
            run_len[c] = 0; run_ticks[c] = 0;
          end
        end else begin
          run_len[c] = 0; run_ticks[c] = 0;
        end
      end
      m_chg   = |(m_rise | m_fall);
      m_s2    = m_s1;
      m_s1    = din;
      m_presc = (m_presc + 1) % TPER;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  // One clock: advance model on the edge, compare all outputs 1ns later
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("model_out",     32'(dout),  32'(m_out));
    chk("model_rise",    32'(drise), 32'(m_rise));
    chk("model_fall",    32'(dfall), 32'(m_fall));
    chk("model_changed", 32'(dchg),  32'(m_chg));
  endtask

  // Cycles until out[ch]==val, checked against the acceptance window
  task automatic measure(input int ch, input logic val, input string name, output int lat);
    lat = -1;
    for (int n = 1; n <= 300; n++) begin
      cycle();
      if (dout[ch] == val) begin lat = n; break; end
    end
    chk_range(name, lat, LAT_MIN, LAT_MAX);
  endtask

  typedef struct {
    logic          rst;
    logic [CH-1:0] in;
    int            cycles;
    logic [CH-1:0] exp_out;
    int            exp_rises;
    int            exp_falls;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nr, nf, lat, total, len;
    logic lvl, bad, seen;

    vecs[0]  = '{1'b1, 4'b0000,   3, 4'b0000, 0, 0};
    vecs[1]  = '{1'b0, 4'b0001, 200, 4'b0001, 1, 0};
    vecs[2]  = '{1'b0, 4'b0000, 200, 4'b0000, 0, 1};
    vecs[3]  = '{1'b0, 4'b0110,  60, 4'b0000, 0, 0};
    vecs[4]  = '{1'b0, 4'b0110, 150, 4'b0110, 2, 0};
    vecs[5]  = '{1'b0, 4'b1111, 200, 4'b1111, 2, 0};
    vecs[6]  = '{1'b0, 4'b0000,  50, 4'b1111, 0, 0};
    vecs[7]  = '{1'b0, 4'b1111, 200, 4'b1111, 0, 0};
    vecs[8]  = '{1'b0, 4'b0000, 200, 4'b0000, 0, 4};
    vecs[9]  = '{1'b1, 4'b1010,   2, 4'b0000, 0, 0};
    vecs[10] = '{1'b0, 4'b1010, 200, 4'b1010, 2, 0};

    for (int i = 0; i < 11; i++) begin
      rst = vecs[i].rst;
      din = vecs[i].in;
      nr = 0; nf = 0;
      repeat (vecs[i].cycles) begin
        cycle();
        nr += $countones(drise);
        nf += $countones(dfall);
      end
      chk($sformatf("vec%0d_out", i),   32'(dout), 32'(vecs[i].exp_out));
      chk($sformatf("vec%0d_rises", i), 32'(nr),   32'(vecs[i].exp_rises));
      chk($sformatf("vec%0d_falls", i), 32'(nf),   32'(vecs[i].exp_falls));
    end

    // Reset with all inputs high: nothing until the first full qualification
    rst = 1'b1; din = 4'b1111;
    repeat (3) begin
      cycle();
      chk("rst_out",  32'(dout),  32'(0));
      chk("rst_rise", 32'(drise), 32'(0));
    end
    rst = 1'b0;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      cycle();
      if (drise != '0) begin lat = n; break; end
    end
    chk_range("rst_first_rise_delay", lat, LAT_MIN, LAT_MAX);
    chk("rst_rise_all", 32'(drise), 32'(4'b1111));
    chk("rst_changed",  32'(dchg),  32'(1));
    cycle();
    chk("rst_rise_single", 32'(drise), 32'(0));
    din = '0;
    repeat (150) cycle();
    chk("rst_all_released", 32'(dout), 32'(0));

    // Clean press and release on channel 0
    din[0] = 1'b1;
    measure(0, 1'b1, "press_latency", lat);
    chk("press_rise_pulse", 32'(drise[0]), 32'(1));
    nr = 0;
    repeat (200 - lat) begin cycle(); nr += int'(drise[0]); end
    chk("press_single_rise", 32'(nr), 32'(0));
    din[0] = 1'b0;
    measure(0, 1'b0, "release_latency", lat);
    chk("release_fall_pulse", 32'(dfall[0]), 32'(1));
    nf = 0;
    repeat (200 - lat) begin cycle(); nf += int'(dfall[0]); end
    chk("release_single_fall", 32'(nf), 32'(0));

    // Bounce on channel 1: segments too short to qualify
    lvl = 1'b1; total = 0; bad = 1'b0;
    while (total < 300) begin
      len = int'($urandom_range(2, 40));
      din[1] = lvl;
      repeat (len) begin cycle(); bad |= drise[1] | dfall[1] | dout[1]; end
      total += len;
      lvl = ~lvl;
    end
    din[1] = 1'b0;
    repeat (20) begin cycle(); bad |= drise[1] | dfall[1] | dout[1]; end
    chk("bounce_no_activity", 32'(bad), 32'(0));

    // Glitch during WAIT_1 on channel 2 restarts qualification
    din[2] = 1'b1;
    repeat (80) cycle();
    din[2] = 1'b0;
    repeat (3) cycle();
    chk("glitch_out_low", 32'(dout[2]), 32'(0));
    din[2] = 1'b1;
    measure(2, 1'b1, "glitch_restart_latency", lat);
    din[2] = 1'b0;
    repeat (150) cycle();

    // Channels 0 and 3 qualify on the same edge
    din = 4'b1001;
    seen = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      cycle();
      if (dchg) begin seen = 1'b1; break; end
    end
    chk("simul_seen",    32'(seen),  32'(1));
    chk("simul_rise",    32'(drise), 32'(4'b1001));
    chk("simul_fall",    32'(dfall), 32'(0));
    chk("simul_out",     32'(dout),  32'(4'b1001));
    cycle();
    chk("simul_chg_one", 32'(dchg),  32'(0));
    chk("simul_rise_one", 32'(drise), 32'(0));
    din = '0;
    repeat (150) cycle();

    // Reset while channel 0 is in WAIT_0 with two ticks counted
    din = 4'b0001;
    repeat (150) cycle();
    chk("midrst_pre_out", 32'(dout[0]), 32'(1));
    din = '0;
    seen = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      cycle();
      if (run_ticks[0] == 2) begin seen = 1'b1; break; end
    end
    chk("midrst_reached_cnt2", 32'(seen), 32'(1));
    rst = 1'b1;
    cycle();
    chk("midrst_out",  32'(dout[0]),  32'(0));
    chk("midrst_fall", 32'(dfall[0]), 32'(0));
    rst = 1'b0;
    cycle();
    chk("midrst_no_fall", 32'(dfall[0]), 32'(0));
    din[0] = 1'b1;
    measure(0, 1'b1, "midrst_requalify_latency", lat);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_channel_debouncer.md
Name: multi_channel_debouncer

Overview:
- Parametrised N-channel switch/button debouncer. Successor to the single-channel tick-sampled debouncer FSM.
- Adds per-channel input synchronisers, a programmable stability count, full symmetric four-state FSMs and one-cycle rise/fall event pulses.
- Sits between raw pad inputs and control logic.
- One shared prescaler generates the sample tick for all channels.

Parameters:
- CHANNELS, 4: number of independent input channels (≥1).
- TICK_BITS, 5: prescaler width. Sample tick period is 2^TICK_BITS clocks.
- STABLE_TICKS, 4: number of consecutive ticks a new level must hold before it is accepted (≥1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  CHANNELS  raw asynchronous inputs, one bit per channel.
- out  output  CHANNELS  debounced levels.
- rise  output  CHANNELS  one-cycle pulse when out[i] goes 0→1.
- fall  output  CHANNELS  one-cycle pulse when out[i] goes 1→0.
- changed  output  1  OR of all rise and fall bits, registered together with them.

Behaviour:
- Clocking and reset: one clock domain (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values:
  - prescaler = 0.
  - All synchroniser flops = 0.
  - Every FSM in ZERO, every stability counter = 0.
  - out, rise, fall, changed = 0.
  - rst asserted mid-operation aborts any pending transition on the next edge; pulses in flight are cleared.
- Prescaler:
  - TICK_BITS-bit free-running counter, wraps naturally.
  - tick = 1 in any cycle where prescaler == all-ones.
  - First tick occurs 2^TICK_BITS−1 cycles after rst deasserts.
  - Shared by all channels.
- Synchroniser: per channel, 2-flop chain. s[i] is the second flop. Latency is 2 clocks from in to s.
- Per-channel FSM, states ZERO, WAIT_1, ONE, WAIT_0. cnt width = max(1, clog2(STABLE_TICKS)).
  - ZERO (out=0): s=1 → WAIT_1, cnt←0. Otherwise stay.
  - WAIT_1 (out=0):
    - s=0 → ZERO (glitch rejected, no pulse).
    - Else on tick: cnt==STABLE_TICKS−1 → ONE, rise pulse; otherwise cnt←cnt+1.
  - ONE (out=1): s=0 → WAIT_0, cnt←0. Otherwise stay.
  - WAIT_0 (out=1):
    - s=1 → ONE (no pulse).
    - Else on tick: cnt==STABLE_TICKS−1 → ZERO, fall pulse; otherwise cnt←cnt+1.
  - Simultaneous s reversal and tick in a WAIT state: the reversal wins, the tick is ignored.
  - Unreachable encodings → ZERO on the next clock.
- Output timing:
  - out, rise, fall and changed are registered and update on the same edge as the state transition into ONE or ZERO.
  - rise/fall are high for exactly one cycle per accepted transition.
  - At most one of rise[i]/fall[i] is high in any cycle.
- Acceptance latency from a clean in edge to out change:
  - minimum (STABLE_TICKS−1)·2^TICK_BITS + 3 clocks.
  - maximum STABLE_TICKS·2^TICK_BITS + 3 clocks.
- Channel independence: channels share only the tick. Any combination of channels may pulse in the same cycle.
- STABLE_TICKS=1: accept on the first tick seen while in the WAIT state.

Test Plan:
- Reset: rst=1 for 3 cycles with in=4'b1111 → out=0, rise=fall=0 during reset and for ≥(STABLE_TICKS−1)·32+3 cycles after release. Then rise=4'b1111 together for exactly one cycle.
- Clean press, defaults, ch0: in[0] 0→1 held 200 cycles → out[0] rises between 99 and 131 cycles after the edge, rise[0] pulses once. Release held 200 cycles → out[0] falls in the same window, fall[0] pulses once.
- Bounce rejection: in[1] toggles 1/0 with periods of 2–40 cycles for 300 cycles, each high segment <90 cycles, ending at 0 → out[1] stays 0, rise[1]/fall[1] never assert.
- Glitch during WAIT: in[2] high 80 cycles, low 3 cycles, high 200 cycles → FSM returns to ZERO and restarts. out[2] rises ≥99 cycles after the final rising edge.
- Simultaneous channels: in[0] and in[3] rise on the same cycle → rise[0] and rise[3] pulse on the same cycle, changed=1 for that single cycle. Other channels are unaffected.
- Mid-operation reset: rst pulsed for 1 cycle while ch0 is in WAIT_0 with cnt=2 → next cycle out[0]=0, no fall pulse. Then in[0]=1 is re-qualified from ZERO with full latency.
